pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Unified hazard controller for the 5-stage RV32IM pipeline: S1 IF, S2 ID, S3 EX, S4 MEM, S5 WB.
- Generalises operand forwarding to N producer stages and never forwards x0.
- Adds load-use stall/bubble insertion, a multi-cycle MUL/DIV busy FSM with countdown, branch/jump flush with priority resolution, and a saturating stall-cycle counter.
- Sits beside the ID/EX boundary and drives the OP1/OP2 forwarding muxes plus the hold/bubble/flush controls of the PC and the pipeline registers.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_FWD, 3, number of forwarding producer stages; index 0 = S3 (nearest), index NUM_FWD-1 = oldest.
- SEL_W, $clog2(NUM_FWD+1), forwarding select width.
- MUL_LAT, 2, EX cycles for MUL/MULH*; must be ≥ 1.
- DIV_LAT, 33, EX cycles for DIV/REM*; must be ≥ 1.
- CNT_W, 32, stall counter width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- RS1_ADDR  in  REG_ADDR_W  rs1 of the instruction in S2.
- RS2_ADDR  in  REG_ADDR_W  rs2 of the instruction in S2.
- RS1_USED, RS2_USED  in  1  the S2 instruction actually reads rs1 / rs2.
- W_EN_FWD  in  NUM_FWD  register-write enable per producer stage.
- W_ADDR_FWD  in  NUM_FWD*REG_ADDR_W  packed destination addresses; stage i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- MEM_READ_S3  in  1  the instruction in S3 is a load.
- MULDIV_START  in  1  an M-extension instruction enters S3 this cycle (1-cycle pulse).
- MULDIV_IS_DIV  in  1  qualifies MULDIV_START: 1 = divide/remainder.
- BJ_SIG  in  1  taken branch or jump resolved in S3.
- OP1_SEL, OP2_SEL  out  SEL_W  0 = register file, i+1 = forward from producer i.
- STALL_PC  out  1  hold the PC.
- STALL_S1  out  1  hold the IF/ID register.
- STALL_S2  out  1  hold the ID/EX register.
- BUBBLE_S2  out  1  load a NOP into ID/EX.
- BUBBLE_S3  out  1  load a NOP into EX/MEM.
- FLUSH_S1, FLUSH_S2  out  1  clear IF/ID and ID/EX.
- MULDIV_BUSY  out  1  FSM is in BUSY.
- MULDIV_DONE  out  1  1-cycle pulse on the last BUSY cycle.
- STALL_CNT  out  CNT_W  count of stalled cycles.

Behaviour:
- Reset: CLK rising edge with RESET=1 sets FSM=IDLE, countdown=0, STALL_CNT=0. All control outputs are 0 on the cycle following reset. RESET mid-BUSY aborts the operation with no DONE pulse.
- Forwarding (combinational, zero latency), per operand:
  - Candidate i is valid when RSx_USED && W_EN_FWD[i] && W_ADDR_FWD[i]==RSx && RSx!=0.
  - Lowest valid index wins; SEL = index+1. No valid candidate gives SEL=0.
  - Computed in all FSM states.
- Load-use (IDLE only):
  - Fires when MEM_READ_S3 && forwarding candidate 0 is valid for either operand.
  - Asserts STALL_PC=1, STALL_S1=1, BUBBLE_S2=1 for exactly one cycle.
  - Next cycle the load is in S4 and is forwarded as index 1; no FSM state is required.
- Flush:
  - BJ_SIG=1 gives FLUSH_S1=FLUSH_S2=1 in the same cycle.
  - Flush overrides load-use: STALL_PC, STALL_S1, BUBBLE_S2 are forced to 0 that cycle.
- FSM IDLE→BUSY:
  - Taken on MULDIV_START in IDLE; countdown loads (IS_DIV ? DIV_LAT : MUL_LAT) - 1.
  - If the loaded value is 0 (latency 1), the FSM stays IDLE and no stall occurs.
  - MULDIV_START has priority over load-use detection in the same cycle.
- FSM BUSY:
  - Outputs: STALL_PC=STALL_S1=STALL_S2=1, BUBBLE_S3=1, MULDIV_BUSY=1.
  - Countdown decrements each cycle. When it reaches 1, MULDIV_DONE=1 that cycle and the next state is IDLE.
  - Load-use detection and flush outputs are masked.
  - MULDIV_START and BJ_SIG are illegal in BUSY: ignored, and flagged by a bench assertion.
- STALL_CNT: +1 on every cycle with STALL_PC=1; saturates at all-ones and does not wrap.
- Simultaneous BJ_SIG and MULDIV_START are architecturally exclusive (same S3 slot). If both arrive, BJ_SIG wins and the FSM stays IDLE.

Decomposition:
- Package hazard_pkg holds:
  - the state enum {IDLE, BUSY};
  - FWD_NONE = 0;
  - the latency defaults;
  - a function computing SEL_W.
- Sub-module fwd_select: a parametrised priority encoder for one operand, instantiated twice (OP1, OP2).

Test Plan:
- Forwarding priority: RS1=5, W_EN_FWD=3'b111, all W_ADDR=5 → OP1_SEL=1. Drop W_EN_FWD[0] → OP1_SEL=2. RS1=0 with all addresses 0 → OP1_SEL=0.
- Load-use: MEM_READ_S3=1, W_ADDR_FWD[0]=7, RS2=7, RS2_USED=1 → STALL_PC=STALL_S1=BUBBLE_S2=1 for one cycle. Next cycle with the load moved to index 1 → OP2_SEL=2, STALL_PC=0.
- Flush vs stall: same stimulus as load-use plus BJ_SIG=1 → FLUSH_S1=FLUSH_S2=1, STALL_PC=0, STALL_CNT unchanged.
- DIV with DIV_LAT=33:
  - MULDIV_START with IS_DIV=1 → MULDIV_BUSY=1 for 32 cycles.
  - MULDIV_DONE pulses on the 32nd cycle.
  - STALL_CNT increases by 32.
  - MUL with MUL_LAT=2 → BUSY for 1 cycle.
- Reset mid-BUSY: RESET on BUSY cycle 10 → next cycle all outputs 0, FSM IDLE, no DONE pulse, STALL_CNT=0.
- Saturation: with CNT_W=4, hold a DIV stall for 20 cycles → STALL_CNT stays at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Multi-cycle M-extension unit: either idle or holding the pipeline.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Operand select value meaning "take the register-file read data".
    localparam int FWD_NONE = 0;

    // Default EX occupancy of multiply and divide instructions.
    localparam int MUL_LAT_DEFAULT = 2;
    localparam int DIV_LAT_DEFAULT = 33;

    // Select width able to encode "none" plus one code per producer stage.
    function automatic int sel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority encoder choosing the nearest producer stage that writes one operand.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 3,
    parameter int SEL_W      = sel_width(NUM_FWD)
) (
    input  logic [REG_ADDR_W-1:0]         rs_addr,
    input  logic                          rs_used,
    input  logic [NUM_FWD-1:0]            w_en,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] w_addr,
    output logic [SEL_W-1:0]              sel
);

    // Scan oldest to nearest so the lowest matching index is the last write and wins.
    always_comb begin
        // NOTE: give every combinational output a default before any branch, otherwise a latch is inferred.
        sel = SEL_W'(FWD_NONE);
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            // NOTE: blocking assignments inside always_comb so later iterations see earlier ones.
            if (rs_used && w_en[i] && (rs_addr != '0) &&
                (w_addr[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
                sel = SEL_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage RV32IM pipeline: operand forwarding,
// load-use bubbles, MUL/DIV busy stalls, branch flushes and a stall counter.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 3,
    parameter int SEL_W      = sel_width(NUM_FWD),
    parameter int MUL_LAT    = MUL_LAT_DEFAULT,
    parameter int DIV_LAT    = DIV_LAT_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [REG_ADDR_W-1:0]         RS1_ADDR,
    input  logic [REG_ADDR_W-1:0]         RS2_ADDR,
    input  logic                          RS1_USED,
    input  logic                          RS2_USED,
    input  logic [NUM_FWD-1:0]            W_EN_FWD,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] W_ADDR_FWD,
    input  logic                          MEM_READ_S3,
    input  logic                          MULDIV_START,
    input  logic                          MULDIV_IS_DIV,
    input  logic                          BJ_SIG,
    output logic [SEL_W-1:0]              OP1_SEL,
    output logic [SEL_W-1:0]              OP2_SEL,
    output logic                          STALL_PC,
    output logic                          STALL_S1,
    output logic                          STALL_S2,
    output logic                          BUBBLE_S2,
    output logic                          BUBBLE_S3,
    output logic                          FLUSH_S1,
    output logic                          FLUSH_S2,
    output logic                          MULDIV_BUSY,
    output logic                          MULDIV_DONE,
    output logic [CNT_W-1:0]              STALL_CNT
);

    localparam int LAT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CD_W    = $clog2(LAT_MAX + 1);

    state_t            state;
    logic [CD_W-1:0]   countdown;
    logic [CD_W-1:0]   start_lat;
    logic              done_q;
    logic              load_use;
    logic [CNT_W-1:0]  stall_cnt;

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD),
        .SEL_W      (SEL_W)
    ) u_fwd_op1 (
        .rs_addr (RS1_ADDR),
        .rs_used (RS1_USED),
        .w_en    (W_EN_FWD),
        .w_addr  (W_ADDR_FWD),
        .sel     (OP1_SEL)
    );

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD),
        .SEL_W      (SEL_W)
    ) u_fwd_op2 (
        .rs_addr (RS2_ADDR),
        .rs_used (RS2_USED),
        .w_en    (W_EN_FWD),
        .w_addr  (W_ADDR_FWD),
        .sel     (OP2_SEL)
    );

    // Remaining BUSY cycles after the start cycle; zero means single-cycle, no stall.
    assign start_lat = MULDIV_IS_DIV ? CD_W'(DIV_LAT - 1) : CD_W'(MUL_LAT - 1);

    // A load in S3 feeding S2 can only be forwarded one cycle later, from S4.
    // A taken branch squashes S2 anyway, and a starting MUL/DIV takes priority.
    assign load_use = MEM_READ_S3 && !BJ_SIG && !MULDIV_START &&
                      ((OP1_SEL == SEL_W'(1)) || (OP2_SEL == SEL_W'(1)));

    // Pipeline hold/bubble/flush controls derived from the FSM state and S3 events.
    always_comb begin
        STALL_PC  = 1'b0;
        STALL_S1  = 1'b0;
        STALL_S2  = 1'b0;
        BUBBLE_S2 = 1'b0;
        BUBBLE_S3 = 1'b0;
        FLUSH_S1  = 1'b0;
        FLUSH_S2  = 1'b0;
        if (state == BUSY) begin
            STALL_PC  = 1'b1;
            STALL_S1  = 1'b1;
            STALL_S2  = 1'b1;
            BUBBLE_S3 = 1'b1;
        end else begin
            FLUSH_S1 = BJ_SIG;
            FLUSH_S2 = BJ_SIG;
            if (load_use) begin
                STALL_PC  = 1'b1;
                STALL_S1  = 1'b1;
                BUBBLE_S2 = 1'b1;
            end
        end
    end

    // MUL/DIV busy FSM with countdown, registered DONE pulse, and saturating stall counter.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (RESET) begin
            state     <= IDLE;
            countdown <= '0;
            done_q    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (STALL_PC && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (MULDIV_START && !BJ_SIG && (start_lat != '0)) begin
                        state     <= BUSY;
                        countdown <= start_lat;
                        done_q    <= (start_lat == CD_W'(1));
                    end
                end
                BUSY: begin
                    countdown <= countdown - CD_W'(1);
                    if (countdown == CD_W'(1)) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end else begin
                        done_q <= (countdown == CD_W'(2));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign MULDIV_BUSY = (state == BUSY);
    assign MULDIV_DONE = done_q;
    assign STALL_CNT   = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller. A second instance with a
// 4-bit counter and single-cycle multiply covers saturation and zero-stall MUL.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_used, rs2_used;
    logic [2:0]  w_en_fwd;
    logic [14:0] w_addr_fwd;
    logic        mem_read_s3, muldiv_start, muldiv_is_div, bj_sig;

    logic [1:0]  op1_sel, op2_sel;
    logic        stall_pc, stall_s1, stall_s2, bubble_s2, bubble_s3;
    logic        flush_s1, flush_s2, muldiv_busy, muldiv_done;
    logic [31:0] stall_cnt;

    logic [1:0]  op1_sel_b, op2_sel_b;
    logic        stall_pc_b, stall_s1_b, stall_s2_b, bubble_s2_b, bubble_s3_b;
    logic        flush_s1_b, flush_s2_b, muldiv_busy_b, muldiv_done_b;
    logic [3:0]  stall_cnt_b;

    always #5 clk = ~clk;

    pipeline_hazard_controller dut (
        .CLK(clk), .RESET(reset),
        .RS1_ADDR(rs1_addr), .RS2_ADDR(rs2_addr),
        .RS1_USED(rs1_used), .RS2_USED(rs2_used),
        .W_EN_FWD(w_en_fwd), .W_ADDR_FWD(w_addr_fwd),
        .MEM_READ_S3(mem_read_s3), .MULDIV_START(muldiv_start),
        .MULDIV_IS_DIV(muldiv_is_div), .BJ_SIG(bj_sig),
        .OP1_SEL(op1_sel), .OP2_SEL(op2_sel),
        .STALL_PC(stall_pc), .STALL_S1(stall_s1), .STALL_S2(stall_s2),
        .BUBBLE_S2(bubble_s2), .BUBBLE_S3(bubble_s3),
        .FLUSH_S1(flush_s1), .FLUSH_S2(flush_s2),
        .MULDIV_BUSY(muldiv_busy), .MULDIV_DONE(muldiv_done),
        .STALL_CNT(stall_cnt)
    );

    pipeline_hazard_controller #(.MUL_LAT(1), .CNT_W(4)) dut_b (
        .CLK(clk), .RESET(reset),
        .RS1_ADDR(rs1_addr), .RS2_ADDR(rs2_addr),
        .RS1_USED(rs1_used), .RS2_USED(rs2_used),
        .W_EN_FWD(w_en_fwd), .W_ADDR_FWD(w_addr_fwd),
        .MEM_READ_S3(mem_read_s3), .MULDIV_START(muldiv_start),
        .MULDIV_IS_DIV(muldiv_is_div), .BJ_SIG(bj_sig),
        .OP1_SEL(op1_sel_b), .OP2_SEL(op2_sel_b),
        .STALL_PC(stall_pc_b), .STALL_S1(stall_s1_b), .STALL_S2(stall_s2_b),
        .BUBBLE_S2(bubble_s2_b), .BUBBLE_S3(bubble_s3_b),
        .FLUSH_S1(flush_s1_b), .FLUSH_S2(flush_s2_b),
        .MULDIV_BUSY(muldiv_busy_b), .MULDIV_DONE(muldiv_done_b),
        .STALL_CNT(stall_cnt_b)
    );

    typedef struct {
        string tag;
        int    op1, op2;
        bit    spc, b2, fl, busy, done;
        int    cnt;
        bit    busy_b, done_b;
        int    cnt_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    int   exp_cnt_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents one set of control outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".op1_sel"},   32'(op1_sel),     32'(e.op1));
            check({e.tag, ".op2_sel"},   32'(op2_sel),     32'(e.op2));
            check({e.tag, ".stall_pc"},  32'(stall_pc),    32'(e.spc));
            check({e.tag, ".stall_s1"},  32'(stall_s1),    32'(e.spc));
            check({e.tag, ".stall_s2"},  32'(stall_s2),    32'(e.busy));
            check({e.tag, ".bubble_s2"}, 32'(bubble_s2),   32'(e.b2));
            check({e.tag, ".bubble_s3"}, 32'(bubble_s3),   32'(e.busy));
            check({e.tag, ".flush_s1"},  32'(flush_s1),    32'(e.fl));
            check({e.tag, ".flush_s2"},  32'(flush_s2),    32'(e.fl));
            check({e.tag, ".busy"},      32'(muldiv_busy), 32'(e.busy));
            check({e.tag, ".done"},      32'(muldiv_done), 32'(e.done));
            check({e.tag, ".stall_cnt"}, stall_cnt,        32'(e.cnt));
            check({e.tag, ".b.busy"},    32'(muldiv_busy_b), 32'(e.busy_b));
            check({e.tag, ".b.done"},    32'(muldiv_done_b), 32'(e.done_b));
            check({e.tag, ".b.stall_cnt"}, 32'(stall_cnt_b), 32'(e.cnt_b));
        end
    end

    // Illegal-in-BUSY inputs must never be driven.
    always @(negedge clk) begin
        if (!reset && muldiv_busy === 1'b1) begin
            assert (!(muldiv_start || bj_sig))
                else $error("MULDIV_START or BJ_SIG driven while BUSY");
        end
    end

    task automatic clr_in();
        rs1_addr = '0; rs2_addr = '0; rs1_used = 0; rs2_used = 0;
        w_en_fwd = '0; w_addr_fwd = '0; mem_read_s3 = 0;
        muldiv_start = 0; muldiv_is_div = 0; bj_sig = 0; reset = 0;
    endtask

    // Push the hand-derived expectation for this cycle, then advance one clock.
    // alt=1 marks the cycle where the single-cycle-MUL instance stays idle.
    task automatic expect_cycle(input string tag, input int op1, input int op2,
                                input bit spc, input bit b2, input bit fl,
                                input bit busy, input bit done, input bit alt);
        exp_t e;
        bit   spc_b;
        e.tag = tag; e.op1 = op1; e.op2 = op2;
        e.spc = spc; e.b2 = b2; e.fl = fl; e.busy = busy; e.done = done;
        e.cnt = exp_cnt;
        e.busy_b = alt ? 1'b0 : busy;
        e.done_b = alt ? 1'b0 : done;
        e.cnt_b  = exp_cnt_b;
        exp_q.push_back(e);
        spc_b = alt ? 1'b0 : spc;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_cnt = 0; exp_cnt_b = 0;
        end else begin
            if (spc) exp_cnt++;
            if (spc_b && exp_cnt_b != 15) exp_cnt_b++;
        end
    endtask

    task automatic load_use_stim();
        mem_read_s3 = 1; w_en_fwd = 3'b001; w_addr_fwd = {5'd0, 5'd0, 5'd7};
        rs2_addr = 7; rs2_used = 1;
    endtask

    initial begin
        clr_in();
        reset = 1;
        @(posedge clk);
        #1;
        clr_in();

        expect_cycle("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);

        rs1_addr = 5; rs1_used = 1; w_en_fwd = 3'b111; w_addr_fwd = {5'd5, 5'd5, 5'd5};
        expect_cycle("fwd_all", 1, 0, 0, 0, 0, 0, 0, 0);

        clr_in();
        rs1_addr = 5; rs1_used = 1; w_en_fwd = 3'b110; w_addr_fwd = {5'd5, 5'd5, 5'd5};
        expect_cycle("fwd_drop0", 2, 0, 0, 0, 0, 0, 0, 0);

        clr_in();
        rs1_addr = 0; rs1_used = 1; w_en_fwd = 3'b111; w_addr_fwd = '0;
        expect_cycle("fwd_x0", 0, 0, 0, 0, 0, 0, 0, 0);

        clr_in();
        rs1_addr = 9; rs1_used = 0; rs2_addr = 9; rs2_used = 1;
        w_en_fwd = 3'b100; w_addr_fwd = {5'd9, 5'd9, 5'd9};
        expect_cycle("fwd_oldest", 0, 3, 0, 0, 0, 0, 0, 0);

        clr_in();
        load_use_stim();
        expect_cycle("load_use", 0, 1, 1, 1, 0, 0, 0, 0);

        clr_in();
        w_en_fwd = 3'b010; w_addr_fwd = {5'd0, 5'd7, 5'd0}; rs2_addr = 7; rs2_used = 1;
        expect_cycle("load_fwd_s4", 0, 2, 0, 0, 0, 0, 0, 0);

        clr_in();
        mem_read_s3 = 1; w_en_fwd = 3'b001; w_addr_fwd = {5'd0, 5'd0, 5'd7};
        rs1_addr = 7; rs1_used = 0;
        expect_cycle("load_unused", 0, 0, 0, 0, 0, 0, 0, 0);

        clr_in();
        load_use_stim(); bj_sig = 1;
        expect_cycle("flush_vs_stall", 0, 1, 0, 0, 1, 0, 0, 0);

        clr_in();
        load_use_stim(); muldiv_start = 1; muldiv_is_div = 0;
        expect_cycle("mul_start", 0, 1, 0, 0, 0, 0, 0, 0);

        clr_in();
        expect_cycle("mul_busy", 0, 0, 1, 0, 0, 1, 1, 1);

        clr_in();
        expect_cycle("mul_after", 0, 0, 0, 0, 0, 0, 0, 0);

        muldiv_start = 1; muldiv_is_div = 1;
        expect_cycle("div_start", 0, 0, 0, 0, 0, 0, 0, 0);

        // Forwarding stays live while BUSY; the load-use pattern is masked.
        for (int k = 1; k <= 32; k++) begin
            clr_in();
            rs1_addr = 3; rs1_used = 1; w_en_fwd = 3'b001; w_addr_fwd = {5'd0, 5'd0, 5'd3};
            mem_read_s3 = 1;
            expect_cycle($sformatf("div_busy%0d", k), 1, 0, 1, 0, 0, 1, (k == 32), 0);
        end

        clr_in();
        expect_cycle("div_after", 0, 0, 0, 0, 0, 0, 0, 0);

        bj_sig = 1; muldiv_start = 1; muldiv_is_div = 1;
        expect_cycle("bj_and_start", 0, 0, 0, 0, 1, 0, 0, 0);

        clr_in();
        expect_cycle("bj_start_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        muldiv_start = 1; muldiv_is_div = 1;
        expect_cycle("div2_start", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 1; k <= 10; k++) begin
            clr_in();
            reset = (k == 10);
            expect_cycle($sformatf("div2_busy%0d", k), 0, 0, 1, 0, 0, 1, 0, 0);
        end

        clr_in();
        for (int k = 1; k <= 3; k++) begin
            expect_cycle($sformatf("after_reset%0d", k), 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
